// File: rtl/fc_engine_param.sv
// Fully-connected layer engine: int8 activations x int8 weights, LANES MACs
// per cycle, signed accumulate, round/shift/saturate (+ optional ReLU) to int8.
//
// Ports:
//   clk, srst          clock, asynchronous active-high reset
//   start              begin a layer (accepted in IDLE only)
//   mode_relu          clamp negative results to 0 (captured at start)
//   shift_amt          requantisation right-shift (captured at start)
//   busy, done         layer in progress / one-cycle completion pulse
//   act_raddr/rdata    activation SRAM read port (1-cycle latency)
//   wgt_raddr/rdata    weight SRAM read port (1-cycle latency)
//   out_wen            output SRAM write enable, active low
//   out_bytemask       output SRAM byte select, active low
//   out_waddr/wdata    output SRAM word address / byte data
module fc_engine_param #(
   parameter int IN_NEURONS  = 64,
   parameter int OUT_NEURONS = 10,
   parameter int LANES       = 4,
   parameter int ACC_W       = 24,
   parameter int ACT_AW      =
      ($clog2(IN_NEURONS / LANES) < 1) ? 1 :
      $clog2(IN_NEURONS / LANES),
   parameter int WGT_AW      =
      ($clog2(OUT_NEURONS * (IN_NEURONS / LANES)) < 1) ? 1 :
      $clog2(OUT_NEURONS * (IN_NEURONS / LANES)),
   parameter int OUT_AW      =
      ($clog2((OUT_NEURONS + 3) / 4) < 1) ? 1 :
      $clog2((OUT_NEURONS + 3) / 4)
) (
   input  logic                 clk,
   input  logic                 srst,
   input  logic                 start,
   input  logic                 mode_relu,
   input  logic [3:0]           shift_amt,
   output logic                 busy,
   output logic                 done,
   output logic [ACT_AW-1:0]    act_raddr,
   input  logic [LANES*8-1:0]   act_rdata,
   output logic [WGT_AW-1:0]    wgt_raddr,
   input  logic [LANES*8-1:0]   wgt_rdata,
   output logic                 out_wen,
   output logic [3:0]           out_bytemask,
   output logic [OUT_AW-1:0]    out_waddr,
   output logic [7:0]           out_wdata
);

   localparam int BEATS = IN_NEURONS / LANES;
   // Neuron counter keeps at least 2 bits so the byte lane o%4 is
   // always addressable.
   localparam int NW =
      ($clog2(OUT_NEURONS + 1) < 2) ? 2 : $clog2(OUT_NEURONS + 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_RUN   = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_WRITE = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]              state_q, state_d;
   logic [ACT_AW-1:0]       beat_q, beat_d;
   logic [NW-1:0]           neuron_q, neuron_d;
   logic [WGT_AW-1:0]       wptr_q, wptr_d;
   logic                    relu_q, relu_d;
   logic [3:0]              shift_q, shift_d;
   logic                    mac_vld_q, mac_vld_d;
   logic                    mac_first_q, mac_first_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;

   logic                    last_beat;
   logic                    last_neuron;
   logic signed [15:0]      prod;
   logic signed [ACC_W-1:0] lane_sum;
   logic signed [ACC_W:0]   rnd_v;
   logic signed [ACC_W:0]   shr_v;
   logic [ACC_W-7:0]        hi_v;
   logic [7:0]              q_v;

   assign last_beat   = (beat_q == ACT_AW'(BEATS - 1));
   assign last_neuron = (neuron_q == NW'(OUT_NEURONS - 1));

   // Control FSM. The weight pointer simply runs over the neuron-major
   // weight layout, so it always equals o*BEATS+k during RUN.
   always_comb begin
      state_d  = state_q;
      beat_d   = beat_q;
      neuron_d = neuron_q;
      wptr_d   = wptr_q;
      relu_d   = relu_q;
      shift_d  = shift_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d  = S_RUN;
               beat_d   = '0;
               neuron_d = '0;
               wptr_d   = '0;
               relu_d   = mode_relu;
               shift_d  = shift_amt;
            end
         end
         S_RUN: begin
            wptr_d = wptr_q + WGT_AW'(1);
            if (last_beat) begin
               state_d = S_WAIT;
               beat_d  = '0;
            end else begin
               beat_d = beat_q + ACT_AW'(1);
            end
         end
         S_WAIT: begin
            state_d = S_WRITE;
         end
         S_WRITE: begin
            if (last_neuron) begin
               state_d = S_DONE;
            end else begin
               state_d  = S_RUN;
               neuron_d = neuron_q + NW'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Data returns one cycle after the address, so the MAC stage is
   // tagged by a registered copy of "was in RUN" and "was beat 0".
   assign mac_vld_d   = (state_q == S_RUN);
   assign mac_first_d = (beat_q == '0);

   always_comb begin
      prod     = '0;
      lane_sum = '0;
      for (int i = 0; i < LANES; i++) begin
         prod     = $signed(act_rdata[8*i +: 8]) *
                    $signed(wgt_rdata[8*i +: 8]);
         lane_sum = lane_sum + ACC_W'(prod);
      end
   end

   always_comb begin
      acc_d = acc_q;
      if (mac_vld_q) begin
         if (mac_first_q) begin
            acc_d = lane_sum;
         end else begin
            acc_d = acc_q + lane_sum;
         end
      end
   end

   // Requantise: round-half-up, arithmetic shift, saturate, optional ReLU.
   // One extra bit absorbs the rounding add.
   always_comb begin
      rnd_v = {acc_q[ACC_W-1], acc_q};
      if (shift_q != 4'd0) begin
         rnd_v = rnd_v + ((ACC_W + 1)'(1) << (shift_q - 4'd1));
      end
      shr_v = rnd_v >>> shift_q;
      // Fits in int8 when bits [ACC_W:7] are all equal.
      hi_v  = shr_v[ACC_W:7];
      if ((&hi_v) || !(|hi_v)) begin
         q_v = shr_v[7:0];
      end else if (shr_v[ACC_W]) begin
         q_v = 8'h80;
      end else begin
         q_v = 8'h7F;
      end
      if (relu_q && q_v[7]) begin
         q_v = 8'h00;
      end
   end

   always_ff @(posedge clk or posedge srst) begin
      if (srst) begin
         state_q     <= S_IDLE;
         beat_q      <= '0;
         neuron_q    <= '0;
         wptr_q      <= '0;
         relu_q      <= 1'b0;
         shift_q     <= '0;
         mac_vld_q   <= 1'b0;
         mac_first_q <= 1'b0;
         acc_q       <= '0;
      end else begin
         state_q     <= state_d;
         beat_q      <= beat_d;
         neuron_q    <= neuron_d;
         wptr_q      <= wptr_d;
         relu_q      <= relu_d;
         shift_q     <= shift_d;
         mac_vld_q   <= mac_vld_d;
         mac_first_q <= mac_first_d;
         acc_q       <= acc_d;
      end
   end

   // Outputs decode straight from registered state, so an asynchronous
   // reset pulls them to their idle values in the same cycle.
   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);
   assign act_raddr = (state_q == S_RUN) ? beat_q : '0;
   assign wgt_raddr = (state_q == S_RUN) ? wptr_q : '0;

   always_comb begin
      out_wen      = 1'b1;
      out_bytemask = 4'b1111;
      out_waddr    = '0;
      out_wdata    = '0;
      if (state_q == S_WRITE) begin
         out_wen      = 1'b0;
         out_bytemask = ~(4'b0001 << neuron_q[1:0]);
         out_waddr    = OUT_AW'(neuron_q >> 2);
         out_wdata    = q_v;
      end
   end

endmodule
